// File: rtl/tdm_demux_pkg.sv
// tdm_pkg: frame-format constants and FSM state type shared by both ends of the TDM link
package tdm_pkg;
  localparam int DEF_WIDTH = 1;
  localparam int DEF_NCH = 2;
  localparam int ERRCNT_W = 8;
  typedef enum logic {IDLE, COLLECT} state_t;
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: TDM beat stream in, parallel frame out
// slave  (demux side): in_data/in_valid/in_sof/out_ready in; in_ready/out_data/out_valid/sync_err out
// master (link side):  mirror of slave
interface tdm_demux_if import tdm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH = DEF_NCH
);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_sof;
  logic in_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic sync_err;
  modport slave (
    input in_data, in_valid, in_sof, out_ready,
    output in_ready, out_data, out_valid, sync_err
  );
  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input in_ready, out_data, out_valid, sync_err
  );
endinterface

// File: rtl/tdm_demux_frame_ctl.sv
// tdm_frame_ctl: frame FSM, channel counter, input handshake and framing-error pulse
// in:  clk, rst_n, in_valid_i, in_sof_i, out_valid_i, out_ready_i
// out: in_ready_o, wr_o/wr_idx_o (shadow write), done_o (last beat accepted), sync_err_o
module tdm_frame_ctl import tdm_pkg::*; #(
  parameter int NCH = DEF_NCH,
  localparam int CW = $clog2(NCH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_i,
  input  logic in_sof_i,
  input  logic out_valid_i,
  input  logic out_ready_i,
  output logic in_ready_o,
  output logic wr_o,
  output logic [CW-1:0] wr_idx_o,
  output logic done_o,
  output logic sync_err_o
);
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic err_q;
  logic last;
  logic acc;
  assign last = state_q == COLLECT && cnt_q == CW'(NCH - 1);
  // only the completing beat stalls, and only while the previous frame is still unread
  assign in_ready_o = !(last && out_valid_i && !out_ready_i);
  assign acc = in_valid_i && in_ready_o;
  assign wr_o = acc && (in_sof_i || state_q == COLLECT);
  assign wr_idx_o = in_sof_i ? '0 : cnt_q;
  assign done_o = acc && !in_sof_i && last;
  assign sync_err_o = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      // stray beat in IDLE or unexpected SOF mid-frame
      err_q <= acc && (state_q == IDLE ? !in_sof_i : in_sof_i);
      if (acc && in_sof_i) begin
        state_q <= COLLECT;
        cnt_q <= CW'(1);
      end else if (acc && state_q == COLLECT) begin
        state_q <= last ? IDLE : COLLECT;
        cnt_q <= last ? '0 : cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: rebuilds NCH-channel parallel words from a SOF-marked TDM beat stream
// in:  clk, rst_n, bus (tdm_demux_if.slave)
// out: err_cnt (only with TDM_DEMUX_ERRCNT_EN defined: saturating sync_err count)
module tdm_demux import tdm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH = DEF_NCH,
  localparam int CW = $clog2(NCH)
) (
  input  logic clk,
  input  logic rst_n,
`ifdef TDM_DEMUX_ERRCNT_EN
  output logic [ERRCNT_W-1:0] err_cnt,
`endif
  tdm_demux_if.slave bus
);
  logic wr;
  logic done;
  logic [CW-1:0] wr_idx;
  logic [(NCH-1)*WIDTH-1:0] shadow_q, shadow_d;
  logic [NCH*WIDTH-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  tdm_frame_ctl #(.NCH(NCH)) u_ctl (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid_i(bus.in_valid),
    .in_sof_i(bus.in_sof),
    .out_valid_i(out_valid_q),
    .out_ready_i(bus.out_ready),
    .in_ready_o(bus.in_ready),
    .wr_o(wr),
    .wr_idx_o(wr_idx),
    .done_o(done),
    .sync_err_o(bus.sync_err)
  );
  // the last channel never lands in shadow: it goes straight into out_data
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NCH - 1; k++)
      if (wr && wr_idx == CW'(k)) shadow_d[k*WIDTH +: WIDTH] = bus.in_data;
    out_data_d = done ? {bus.in_data, shadow_q} : out_data_q;
    out_valid_d = done || (out_valid_q && !bus.out_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.out_data = out_data_q;
  assign bus.out_valid = out_valid_q;
`ifdef TDM_DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (bus.sync_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed self-checking bench for tdm_demux with default NCH=2, WIDTH=1
module tb_tdm_demux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int f0;
  always #5 clk = ~clk;
  tdm_demux_if #(.WIDTH(1), .NCH(2)) bus ();
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif
  tdm_demux #(.WIDTH(1), .NCH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef TDM_DEMUX_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic sof, input logic d);
    bus.in_valid = 1'b1;
    bus.in_sof = sof;
    bus.in_data = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_data = 1'b0;
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_data = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    idle();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_sync_err", bus.sync_err, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 2; k++) begin
          f0 = failures;
          beat(1'b1, 1'(i));
          beat(1'b0, 1'(j));
          chk($sformatf("frm%0d%0d%0d_valid", i, j, k), bus.out_valid, 1);
          chk($sformatf("frm%0d%0d%0d_word", i, j, k), bus.out_data, {30'd0, 1'(j), 1'(i)});
          chk($sformatf("frm%0d%0d%0d_sel", i, j, k), bus.out_data[k], k ? j : i);
          $display("case i=%0d j=%0d k=%0d %s", i, j, k, failures == f0 ? "PASS" : "FAIL");
        end
    idle();
    chk("drain_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    chk("bp_first_valid", bus.out_valid, 1);
    chk("bp_first_data", bus.out_data, 2'b01);
    beat(1'b1, 1'b0);
    chk("bp_sof_accepted_data", bus.out_data, 2'b01);
    bus.in_valid = 1'b1;
    bus.in_data = 1'b1;
    #1;
    chk("bp_last_stalled", bus.in_ready, 0);
    idle();
    chk("bp_hold_data", bus.out_data, 2'b01);
    chk("bp_hold_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    idle();
    bus.in_valid = 1'b0;
    bus.in_data = 1'b0;
    chk("bp_b2b_valid", bus.out_valid, 1);
    chk("bp_b2b_data", bus.out_data, 2'b10);
    idle();
    chk("bp_drained", bus.out_valid, 0);
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    chk("rs_err_pulse", bus.sync_err, 1);
    chk("rs_no_valid", bus.out_valid, 0);
    beat(1'b0, 1'b1);
    chk("rs_err_clear", bus.sync_err, 0);
    chk("rs_valid", bus.out_valid, 1);
    chk("rs_data", bus.out_data, 2'b10);
    idle();
    bus.in_sof = 1'b1;
    idle();
    bus.in_sof = 1'b0;
    chk("sof_no_valid_ignored", bus.sync_err, 0);
    beat(1'b0, 1'b1);
    chk("nosof_err", bus.sync_err, 1);
    chk("nosof_no_valid", bus.out_valid, 0);
    idle();
    chk("nosof_err_clear", bus.sync_err, 0);
    chk("nosof_still_no_valid", bus.out_valid, 0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    chk("nosof_recover", bus.out_data, 2'b10);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("errcnt_two", err_cnt, 8'd2);
`endif
    beat(1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_data", bus.out_data, 0);
    chk("mrst_in_ready", bus.in_ready, 1);
    idle();
    rst_n = 1'b1;
    idle();
    chk("mrst_no_frame", bus.out_valid, 0);
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    chk("mrst_next_valid", bus.out_valid, 1);
    chk("mrst_next_data", bus.out_data, 2'b11);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("errcnt_reset", err_cnt, 8'd0);
    idle();
    bus.in_valid = 1'b1;
    bus.in_sof = 1'b0;
    bus.in_data = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    idle();
    chk("errcnt_sat", err_cnt, 8'hFF);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
